// File: rtl/proc_mem_responder.sv
// ---------------------------------------------------------------------------
// proc_mem_responder
// Self-checking memory model for processor benches. Serves reads with a fixed
// pipeline latency, returns a built-in reset vector at the two vector bytes
// until they are written, accepts bench preloads, and compares every processor
// write against a FIFO of expected (address, data) pairs.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   address, wr_data,     processor bus; wr_enable low means a read cycle
//   wr_enable
//   rd_data, rd_valid     read data RD_LATENCY cycles after issue
//   load_en/addr/data     bench preload port (wins the array write)
//   exp_valid/addr/data   expected-write push port
//   exp_ready, exp_count  FIFO not-full flag and occupancy
//   mismatch              one-cycle pulse the cycle after a failed compare
//   pass_cnt, fail_cnt,   saturating result counters
//   unexp_cnt
// ---------------------------------------------------------------------------
module proc_mem_responder #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 8,
    parameter int          RD_LATENCY   = 1,
    parameter int          EXP_DEPTH    = 8,
    parameter logic [15:0] RESET_VECTOR = 16'h8000,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        address,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         wr_enable,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    input  logic                         load_en,
    input  logic [ADDR_WIDTH-1:0]        load_addr,
    input  logic [DATA_WIDTH-1:0]        load_data,
    input  logic                         exp_valid,
    input  logic [ADDR_WIDTH-1:0]        exp_addr,
    input  logic [DATA_WIDTH-1:0]        exp_data,
    output logic                         exp_ready,
    output logic [$clog2(EXP_DEPTH):0]   exp_count,
    output logic                         mismatch,
    output logic [CNT_WIDTH-1:0]         pass_cnt,
    output logic [CNT_WIDTH-1:0]         fail_cnt,
    output logic [CNT_WIDTH-1:0]         unexp_cnt
);

    localparam int PTR_W = $clog2(EXP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] VLO = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] VHI = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] VEC_LO = DATA_WIDTH'(RESET_VECTOR[7:0]);
    localparam logic [DATA_WIDTH-1:0] VEC_HI = DATA_WIDTH'(RESET_VECTOR[15:8]);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic                  ovr_lo_q, ovr_hi_q;
    logic                  arr_we_s;
    logic [ADDR_WIDTH-1:0] arr_addr_s;
    logic [DATA_WIDTH-1:0] arr_data_s;
    logic [DATA_WIDTH-1:0] rd_val_s;

    logic [RD_LATENCY-1:0] pv_q;
    logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];

    logic [ADDR_WIDTH-1:0] fa_q [EXP_DEPTH];
    logic [DATA_WIDTH-1:0] fd_q [EXP_DEPTH];
    logic [PTR_W-1:0]      wp_q, rp_q;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  push_s, pop_s, empty_s, head_match_s;

    logic [CNT_WIDTH-1:0]  pass_q, fail_q, unexp_q;
    logic                  mismatch_q;

    // Array write select: preload beats the processor write; nothing is written in reset.
    always_comb begin
        arr_we_s   = 1'b0;
        arr_addr_s = address;
        arr_data_s = wr_data;
        if (reset) begin
            arr_we_s = 1'b0;
        end else if (load_en) begin
            arr_we_s   = 1'b1;
            arr_addr_s = load_addr;
            arr_data_s = load_data;
        end else if (wr_enable) begin
            arr_we_s = 1'b1;
        end else begin
            arr_we_s = 1'b0;
        end
    end

    // Memory array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (arr_we_s) begin
            mem_q[arr_addr_s] <= arr_data_s;
        end
    end

    // Vector override flags: set by any array write to the vector bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_lo_q <= 1'b0;
            ovr_hi_q <= 1'b0;
        end else if (arr_we_s) begin
            if (arr_addr_s == VLO) ovr_lo_q <= 1'b1;
            if (arr_addr_s == VHI) ovr_hi_q <= 1'b1;
        end
    end

    // Read value: array contents unless a vector byte has not yet been overwritten.
    always_comb begin
        rd_val_s = mem_q[address];
        if (address == VLO && !ovr_lo_q) begin
            rd_val_s = VEC_LO;
        end else if (address == VHI && !ovr_hi_q) begin
            rd_val_s = VEC_HI;
        end else begin
            rd_val_s = mem_q[address];
        end
    end

    // Read pipeline; data only advances with a valid token so write slots hold rd_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= ~wr_enable;
            if (!wr_enable) pd_q[0] <= rd_val_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign rd_valid = pv_q[RD_LATENCY-1];
    assign rd_data  = pd_q[RD_LATENCY-1];

    assign empty_s      = (cnt_q == '0);
    assign exp_ready    = (cnt_q < (PTR_W+1)'(EXP_DEPTH));
    assign push_s       = exp_valid && exp_ready;
    assign pop_s        = wr_enable && !empty_s;
    assign head_match_s = (fa_q[rp_q] == address) && (fd_q[rp_q] == wr_data);

    // Occupancy next state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push_s && !pop_s) begin
            cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (!push_s && pop_s) begin
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FIFO storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            fa_q[wp_q] <= exp_addr;
            fd_q[wp_q] <= exp_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_s) wp_q <= wp_q + PTR_W'(1);
            if (pop_s)  rp_q <= rp_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Write checker: compares against the head visible at the start of the cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q     <= '0;
            fail_q     <= '0;
            unexp_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            if (wr_enable) begin
                if (empty_s) begin
                    unexp_q <= sat_inc(unexp_q);
                end else if (head_match_s) begin
                    pass_q <= sat_inc(pass_q);
                end else begin
                    fail_q     <= sat_inc(fail_q);
                    mismatch_q <= 1'b1;
                end
            end
        end
    end

    assign exp_count = cnt_q;
    assign mismatch  = mismatch_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign unexp_cnt = unexp_q;

endmodule
